// File: rtl/npu_clk_pkg.sv
// Shared types and clock-derived constants for the NPU clock/reset sequencing logic.
// The default intervals are derived from the PLL output frequency.
package npu_clk_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STABLE = 2'd1,
    RUN    = 2'd2
  } seq_state_t;

  localparam int unsigned CLK_HZ             = 32'd47_250_000;
  // 100 us of stable lock, 10 ms overall lock budget
  localparam int unsigned DEF_STABLE_CYCLES  = CLK_HZ / 32'd10_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = CLK_HZ / 32'd100;
  localparam int unsigned DEF_SYNC_STAGES    = 32'd2;
  localparam int unsigned DEF_CNT_W          = 32'd8;

  function automatic int unsigned seq_cnt_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles) + 32'd1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser for bringing an asynchronous level into the clk domain.
// Synchronous active-high reset clears every stage.
module bit_sync #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the NPU core in reset until the PLL lock flag has been stable for a programmable
// interval; re-asserts reset on lock loss, counts losses and flags a lock timeout.
module pll_lock_sequencer
  import npu_clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             sys_rst,
  output logic             ready,
  output logic             run_start,
  output logic             lock_timeout,
  output logic [CNT_W-1:0] lock_lost_cnt
);

  localparam int unsigned      CW           = seq_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE      = CW'(1);
  localparam logic [CW-1:0]    STABLE_LAST  = CW'(STABLE_CYCLES - 32'd1);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LOST_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOST_MAX     = '1;

  logic             lock_s;
  seq_state_t       state_q,         state_d;
  logic [CW-1:0]    cnt_q,           cnt_d;
  logic             sys_rst_q,       sys_rst_d;
  logic             ready_q,         ready_d;
  logic             run_start_q,     run_start_d;
  logic             lock_timeout_q,  lock_timeout_d;
  logic [CNT_W-1:0] lock_lost_cnt_q, lock_lost_cnt_d;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    lock_timeout_d  = lock_timeout_q;
    lock_lost_cnt_d = lock_lost_cnt_q;

    case (state_q)
      WAIT: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // counter parks here so the flag keeps re-asserting without wrapping
          lock_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT;
          cnt_d   = '0;
          if (lock_lost_cnt_q != LOST_MAX) begin
            lock_lost_cnt_d = lock_lost_cnt_q + LOST_ONE;
          end else begin
            lock_lost_cnt_d = lock_lost_cnt_q;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase

    // outputs are registered from the next state so they change with the state itself
    sys_rst_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
    run_start_d = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WAIT;
      cnt_q           <= '0;
      sys_rst_q       <= 1'b1;
      ready_q         <= 1'b0;
      run_start_q     <= 1'b0;
      lock_timeout_q  <= 1'b0;
      lock_lost_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sys_rst_q       <= sys_rst_d;
      ready_q         <= ready_d;
      run_start_q     <= run_start_d;
      lock_timeout_q  <= lock_timeout_d;
      lock_lost_cnt_q <= lock_lost_cnt_d;
    end
  end

  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign run_start     = run_start_q;
  assign lock_timeout  = lock_timeout_q;
  assign lock_lost_cnt = lock_lost_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed edge numbers.
module tb_pll_lock_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int TMO    = 64;
  localparam int CW     = 2;
  localparam int LMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_lock = 1'b0;
  logic          sys_rst;
  logic          ready;
  logic          run_start;
  logic          lock_timeout;
  logic [CW-1:0] lock_lost_cnt;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  pll_lock_sequencer #(
    .SYNC_STAGES    (SYNC),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .run_start     (run_start),
    .lock_timeout  (lock_timeout),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  // Reference model: the lock flag seen by the sequencer is pll_lock delayed SYNC
  // edges; RUN is reached once STABLE+1 consecutive high samples have been seen.
  bit   m_valid = 1'b0;
  bit   m_pipe [SYNC];
  int   m_hi, m_lo, m_lost;
  bit   m_seen, m_ready, m_start, m_to;

  always @(posedge clk) begin
    bit ls;
    int thr;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_hi = 0; m_lo = 0; m_lost = 0;
      m_seen = 1'b0; m_ready = 1'b0; m_start = 1'b0; m_to = 1'b0;
      m_valid = 1'b1;
    end else begin
      ls = m_pipe[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = pll_lock;
      if (ls) begin
        m_hi++; m_lo = 0; m_seen = 1'b1;
      end else begin
        if (m_hi >= STABLE + 1 && m_lost < LMAX) m_lost++;
        m_hi = 0; m_lo++;
      end
      // after leaving STABLE/RUN the first low sample is the exit edge, not a WAIT cycle
      thr = TMO + (m_seen ? 1 : 0);
      if (!ls && m_lo >= thr) m_to = 1'b1;
      m_ready = (m_hi >= STABLE + 1);
      m_start = (m_hi == STABLE + 1);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_sys_rst", sys_rst, !m_ready);
      chk("m_ready", ready, m_ready);
      chk("m_run_start", run_start, m_start);
      chk("m_lock_timeout", lock_timeout, m_to);
      chk("m_lock_lost_cnt", lock_lost_cnt, m_lost);
    end
  end

  task automatic at_edge(input int k);
    while (edge_cnt < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    at_edge(edge_cnt + n);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, n, r;

    // clean lock: reset edges 1-4, lock after edge 10, release at edge 29
    do_reset(4);
    at_edge(10); pll_lock = 1'b1;
    at_edge(28); chk("clean_sys_rst_28", sys_rst, 1);
    at_edge(29); chk("clean_sys_rst_29", sys_rst, 0);
    chk("clean_ready_29", ready, 1);
    chk("clean_start_29", run_start, 1);
    chk("clean_lost", lock_lost_cnt, 0);
    chk("clean_to", lock_timeout, 0);
    at_edge(30); chk("clean_start_30", run_start, 0);

    // one-cycle glitch in STABLE
    pll_lock = 1'b0;
    do_reset(4);
    b = edge_cnt;
    at_edge(b + 1);  pll_lock = 1'b1;
    at_edge(b + 9);  pll_lock = 1'b0;
    at_edge(b + 10); pll_lock = 1'b1;
    at_edge(b + 28); chk("glitch_sys_rst_pre", sys_rst, 1);
    at_edge(b + 29); chk("glitch_sys_rst_rel", sys_rst, 0);
    chk("glitch_lost", lock_lost_cnt, 0);

    // loss in RUN and re-lock
    n = b + 35;
    at_edge(n);      pll_lock = 1'b0;
    at_edge(n + 2);  chk("loss_ready_n2", ready, 1);
    at_edge(n + 3);  chk("loss_sys_rst_n3", sys_rst, 1);
    chk("loss_ready_n3", ready, 0);
    chk("loss_lost_n3", lock_lost_cnt, 1);
    at_edge(n + 5);  pll_lock = 1'b1;
    at_edge(n + 23); chk("relock_sys_rst_pre", sys_rst, 1);
    at_edge(n + 24); chk("relock_ready", ready, 1);
    chk("relock_start", run_start, 1);
    chk("relock_lost", lock_lost_cnt, 1);

    // timeout from reset, then a late lock
    pll_lock = 1'b0;
    do_reset(2);
    b = edge_cnt;
    at_edge(b + 63); chk("tmo_63", lock_timeout, 0);
    at_edge(b + 64); chk("tmo_64", lock_timeout, 1);
    at_edge(b + 70); pll_lock = 1'b1;
    at_edge(b + 88); chk("tmo_sys_rst_pre", sys_rst, 1);
    at_edge(b + 89); chk("tmo_ready", ready, 1);
    chk("tmo_start", run_start, 1);
    chk("tmo_sticky", lock_timeout, 1);

    // lost-count saturation at 2 bits
    for (int i = 0; i < 5; i++) begin
      n = edge_cnt + 2;
      at_edge(n);      pll_lock = 1'b0;
      at_edge(n + 3);  chk("sat_lost", lock_lost_cnt, (i + 1 > LMAX) ? LMAX : i + 1);
      at_edge(n + 5);  pll_lock = 1'b1;
      at_edge(n + 24); chk("sat_ready", ready, 1);
    end

    // reset mid-RUN with lock held
    r = edge_cnt + 3;
    at_edge(r - 1); rst = 1'b1;
    at_edge(r);     rst = 1'b0;
    chk("rstrun_sys_rst", sys_rst, 1);
    chk("rstrun_ready", ready, 0);
    chk("rstrun_lost", lock_lost_cnt, 0);
    chk("rstrun_to", lock_timeout, 0);
    at_edge(r + 18); chk("rstrun_sys_rst_pre", sys_rst, 1);
    at_edge(r + 19); chk("rstrun_sys_rst_rel", sys_rst, 0);
    chk("rstrun_start", run_start, 1);

    at_edge(edge_cnt + 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sits directly downstream of the board PLL wrapper: 27 MHz in, 47.25 MHz `clkout`, plus an asynchronous `lock`.
- Runs on the PLL output clock and synchronises the PLL lock flag.
- Holds the NPU core in reset until lock has been continuously stable for a programmable interval.
- Re-asserts reset on any lock loss, counts loss events, and flags a sticky timeout if lock never arrives.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the pll_lock synchroniser (legal range 2..4).
- STABLE_CYCLES, 4725: consecutive synchronised-lock cycles required before releasing reset (100 us at 47.25 MHz); must be ≥ 2.
- TIMEOUT_CYCLES, 472500: cycles without lock before lock_timeout is set (10 ms); must be greater than STABLE_CYCLES.
- CNT_W, 8: width of lock_lost_cnt.

Ports:
- clk  input  1  PLL output clock (47.25 MHz); the only clock.
- rst  input  1  synchronous, active-high reset.
- pll_lock  input  1  PLL lock flag, asynchronous to clk.
- sys_rst  output  1  registered, synchronous, active-high reset to the NPU core.
- ready  output  1  high while in RUN.
- run_start  output  1  one-cycle pulse on the first RUN cycle.
- lock_timeout  output  1  sticky: lock not seen within TIMEOUT_CYCLES.
- lock_lost_cnt  output  CNT_W  saturating count of RUN-to-lock-loss events.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchroniser flops cleared, state=WAIT, internal counter cnt=0.
  - Outputs: sys_rst=1, ready=0, run_start=0, lock_timeout=0, lock_lost_cnt=0.
  - rst overrides everything, including mid-RUN; no loss is counted for a reset-driven exit.
- Synchroniser: lock_s is pll_lock delayed through SYNC_STAGES flops. All FSM decisions use lock_s only.
- Counter cnt: width is clog2(TIMEOUT_CYCLES)+1.
- State WAIT:
  - lock_s=0: cnt increments.
  - When cnt reaches TIMEOUT_CYCLES-1, lock_timeout sets and cnt holds (saturates).
  - lock_s=1: go to STABLE, cnt=0.
- State STABLE:
  - lock_s=0: go to WAIT, cnt=0. This is a glitch; lock_lost_cnt is unchanged.
  - lock_s=1 and cnt=STABLE_CYCLES-1: go to RUN.
  - Otherwise cnt increments.
- State RUN:
  - lock_s=0: go to WAIT, cnt=0, lock_lost_cnt increments, saturating at all-ones.
- Output registration:
  - sys_rst = registered (next_state != RUN); ready = registered (next_state == RUN).
  - run_start is high on the cycle ready first goes high.
  - sys_rst and ready are always complementary after reset.
- Latency, lock to release: sys_rst falls SYNC_STAGES+STABLE_CYCLES+1 edges after pll_lock rises and stays high.
- Latency, loss to reset: sys_rst rises SYNC_STAGES+1 edges after pll_lock falls.
- lock_timeout:
  - Cleared only by rst.
  - Stays set even if lock is later achieved and RUN is entered.
  - A second WAIT period after a loss keeps counting toward the timeout (cnt restarts at 0).
- Simultaneous events: lock_s falling on the same edge STABLE would have completed gives WAIT. Loss takes priority; no run_start.
- No combinational path from any input to any output.

Decomposition:
- Package npu_clk_pkg holds:
  - Enum seq_state_t {WAIT, STABLE, RUN}.
  - Constants CLK_HZ=47_250_000, DEF_STABLE_CYCLES, DEF_TIMEOUT_CYCLES.
- One sub-module: bit_sync. It is a parameterised N-stage single-bit synchroniser with synchronous active-high reset, reusable for other async inputs.

Test Plan (bench overrides STABLE_CYCLES=16, TIMEOUT_CYCLES=64, SYNC_STAGES=2):
- Clean lock: rst for 4 cycles, pll_lock rises at edge 10 and stays high.
  - sys_rst falls at edge 29 (10+2+16+1); ready rises at edge 29; run_start high for exactly edge 29.
  - lock_lost_cnt=0, lock_timeout=0.
- Glitch during STABLE: pll_lock high 8 cycles, low 1 cycle, then high.
  - sys_rst stays 1 throughout the glitch; release comes 19 edges after the final rise.
  - lock_lost_cnt stays 0.
- Loss in RUN: after release, drop pll_lock at edge N.
  - sys_rst=1 and ready=0 at edge N+3; lock_lost_cnt=1.
  - Re-raise pll_lock: release again after 19 edges, second run_start pulse.
- Timeout: hold pll_lock=0 from reset.
  - lock_timeout rises after 64 WAIT cycles and stays set.
  - A later lock completes the normal sequence; lock_timeout is still 1 in RUN.
- Saturation: with CNT_W=2, run 5 lock/loss cycles.
  - lock_lost_cnt reads 1, 2, 3, 3, 3.
- Reset mid-RUN: assert rst for 1 cycle while ready=1 with lock held.
  - Next edge: sys_rst=1, ready=0, lock_lost_cnt=0, lock_timeout=0.
  - Re-release occurs 19 edges after rst deasserts.
